// File: rtl/fetch_pc_stage.sv
// IF stage of the 5-stage datapath: PC register, instruction-memory address,
// IF/ID pipeline register, and stall/flush statistics fed by the hazard unit.
module fetch_pc_stage #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned PC_INC    = 1,
  parameter int unsigned NOP_INSTR = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_hold,
  input  logic               fd_hold,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               clear_stats,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] fd_instr,
  output logic [PC_W-1:0]    fd_pc,
  output logic [PC_W-1:0]    fd_pc_next,
  output logic               fd_valid,
  output logic [1:0]         fetch_state,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count,
  output logic               err_hold_mis
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10,
    ST_BOOT  = 2'b11
  } fetch_state_e;

  localparam logic [PC_W-1:0]    LP_RESET_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]    LP_PC_INC   = PC_W'(PC_INC);
  localparam logic [INSTR_W-1:0] LP_NOP      = INSTR_W'(NOP_INSTR);
  localparam logic [CNT_W-1:0]   LP_CNT_MAX  = '1;

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_fd_instr;
  logic [PC_W-1:0]    r_fd_pc;
  logic [PC_W-1:0]    r_fd_pc_next;
  logic               r_fd_valid;
  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_count;
  logic               r_err_hold_mis;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_stall_inc;
  logic               w_hold_mis;

  assign w_pc_inc    = r_pc + LP_PC_INC;
  assign w_stall_inc = pc_hold && !branch_taken;
  // IF/ID holds while the PC moves on: the instruction fetched this cycle is dropped.
  assign w_hold_mis  = fd_hold && !pc_hold && !branch_taken;

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= LP_RESET_PC;
    end else if (branch_taken) begin
      r_pc <= branch_target;
    end else if (!pc_hold) begin
      r_pc <= w_pc_inc;
    end
  end

  // IF/ID pipeline register; a taken branch squashes the slot but keeps its PC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fd_instr   <= LP_NOP;
      r_fd_pc      <= '0;
      r_fd_pc_next <= '0;
      r_fd_valid   <= 1'b0;
    end else if (branch_taken) begin
      r_fd_instr <= LP_NOP;
      r_fd_valid <= 1'b0;
    end else if (!fd_hold) begin
      r_fd_instr   <= imem_rdata;
      r_fd_pc      <= r_pc;
      r_fd_pc_next <= w_pc_inc;
      r_fd_valid   <= 1'b1;
    end
  end

  // Fetch state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next fetch state
  always_comb begin
    w_state_next = ST_RUN;
    if (branch_taken) begin
      w_state_next = ST_FLUSH;
    end else if (pc_hold) begin
      w_state_next = ST_STALL;
    end
  end

  // Saturating statistics and sticky hold-mismatch flag
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_err_hold_mis <= 1'b0;
    end else begin
      if (w_stall_inc && (r_stall_cycles != LP_CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (branch_taken && (r_flush_count != LP_CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
      if (w_hold_mis) begin
        r_err_hold_mis <= 1'b1;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign fd_instr     = r_fd_instr;
  assign fd_pc        = r_fd_pc;
  assign fd_pc_next   = r_fd_pc_next;
  assign fd_valid     = r_fd_valid;
  assign fetch_state  = r_state;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign err_hold_mis = r_err_hold_mis;

endmodule
